// File: rtl/inst_mem.sv
// Loadable instruction memory: an image is streamed in from word 0, then the CPU
// fetches from it with a one-cycle registered read path.
module inst_mem #(
    parameter int XLEN = 32,
    parameter int DEPTH = 256,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic [AW:0]     load_count,
    output logic            loaded,
    input  logic            fetch_req,
    input  logic [31:0]     fetch_addr,
    output logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_inst,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_load_count;
    logic            r_load_ready;
    logic            r_loaded;
    logic            r_fetch_ready;
    logic            r_fetch_valid;
    logic [XLEN-1:0] r_fetch_inst;
    logic            r_fetch_fault;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_write;
    logic            w_load_done;
    logic            w_fetch_accept;
    logic            w_fetch_fault;
    logic [AW-1:0]   w_fetch_idx;

    // load_start takes priority, so a word presented alongside it is dropped.
    assign w_write        = (r_state == S_LOAD) && load_valid && !load_start;
    assign w_load_done    = load_last || (r_wptr == AW'(DEPTH - 1));
    assign w_fetch_accept = fetch_req && r_fetch_ready;
    assign w_fetch_fault  = (fetch_addr[1:0] != 2'b00) ||
                            ({2'b00, fetch_addr[31:2]} >= 32'(DEPTH));
    assign w_fetch_idx    = fetch_addr[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_EMPTY;
            r_wptr        <= '0;
            r_load_count  <= '0;
            r_load_ready  <= 1'b0;
            r_loaded      <= 1'b0;
            r_fetch_ready <= 1'b0;
        end else if (load_start) begin
            r_state       <= S_LOAD;
            r_wptr        <= '0;
            r_load_count  <= '0;
            r_load_ready  <= 1'b1;
            r_loaded      <= 1'b0;
            r_fetch_ready <= 1'b0;
        end else if (w_write) begin
            r_wptr       <= r_wptr + AW'(1);
            r_load_count <= r_load_count + (AW+1)'(1);
            if (w_load_done) begin
                r_state       <= S_RUN;
                r_load_ready  <= 1'b0;
                r_loaded      <= 1'b1;
                r_fetch_ready <= 1'b1;
            end
        end
    end

    // Contents deliberately survive reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= load_data;
        end
    end

    // Result registers hold their value between accepted fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_inst  <= '0;
            r_fetch_fault <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_fetch_fault <= w_fetch_fault;
                r_fetch_inst  <= w_fetch_fault ? NOP_INST : r_mem[w_fetch_idx];
            end
        end
    end

    assign load_ready  = r_load_ready;
    assign load_count  = r_load_count;
    assign loaded      = r_loaded;
    assign fetch_ready = r_fetch_ready;
    assign fetch_valid = r_fetch_valid;
    assign fetch_inst  = r_fetch_inst;
    assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: load, fetch, fault, full-depth load, restart and
// mid-load reset, with hand-computed expectations.
module tb_inst_mem;

    localparam int XLEN = 32;
    localparam int DEPTH = 256;
    localparam int AW = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic            clk;
    logic            rst_n;
    logic            load_start;
    logic            load_valid;
    logic [XLEN-1:0] load_data;
    logic            load_last;
    logic            load_ready;
    logic [AW:0]     load_count;
    logic            loaded;
    logic            fetch_req;
    logic [31:0]     fetch_addr;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_inst;
    logic            fetch_fault;

    int assertCount = 0;
    int failCount = 0;

    logic [31:0] prog [4];

    inst_mem #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_last(load_last),
        .load_ready(load_ready),
        .load_count(load_count),
        .loaded(loaded),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_inst(fetch_inst),
        .fetch_fault(fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic start, input logic valid, input logic [31:0] data,
                                 input logic last, input logic freq, input logic [31:0] addr);
        load_start = start;
        load_valid = valid;
        load_data  = data;
        load_last  = last;
        fetch_req  = freq;
        fetch_addr = addr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_load_ready"}, 64'(load_ready), 64'd0);
        checkOutput({tag, "_load_count"}, 64'(load_count), 64'd0);
        checkOutput({tag, "_loaded"}, 64'(loaded), 64'd0);
        checkOutput({tag, "_fetch_ready"}, 64'(fetch_ready), 64'd0);
        checkOutput({tag, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
        checkOutput({tag, "_fetch_inst"}, 64'(fetch_inst), 64'd0);
        checkOutput({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] inst, input logic fault);
        checkOutput({tag, "_valid"}, 64'(fetch_valid), 64'd1);
        checkOutput({tag, "_inst"}, 64'(fetch_inst), 64'(inst));
        checkOutput({tag, "_fault"}, 64'(fetch_fault), 64'(fault));
    endtask

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00100113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #3 checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch attempted while EMPTY must not be accepted.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("empty_fetch_ready", 64'(fetch_ready), 64'd0);
        checkOutput("empty_fetch_valid", 64'(fetch_valid), 64'd0);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("start_load_ready", 64'(load_ready), 64'd1);
        checkOutput("start_fetch_valid", 64'(fetch_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, prog[i], i == 3, 1'b1, 32'h0);
            tick();
            checkOutput("load_fetch_valid", 64'(fetch_valid), 64'd0);
            checkOutput("load_count", 64'(load_count), 64'(i + 1));
        end
        checkOutput("prog_loaded", 64'(loaded), 64'd1);
        checkOutput("prog_load_ready", 64'(load_ready), 64'd0);
        checkOutput("prog_fetch_ready", 64'(fetch_ready), 64'd1);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("idle_fetch_valid", 64'(fetch_valid), 64'd0);

        // Back-to-back fetches produce one result per cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4));
            tick();
            checkFetch("b2b", prog[i], 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("hold_valid", 64'(fetch_valid), 64'd0);
        checkOutput("hold_inst", 64'(fetch_inst), 64'(prog[3]));

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6);
        tick();
        checkFetch("misaligned", NOP, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
        tick();
        checkFetch("out_of_range", NOP, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
        tick();
        checkFetch("fault_clear", prog[2], 1'b0);

        // load_valid outside LOAD is ignored.
        applyStimulus(1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("run_ignore_count", 64'(load_count), 64'd4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        checkFetch("run_ignore_word", prog[0], 1'b0);

        // Restart with a word and a fetch in the same cycle.
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h4);
        tick();
        checkOutput("restart_count", 64'(load_count), 64'd0);
        checkOutput("restart_loaded", 64'(loaded), 64'd0);
        checkOutput("restart_load_ready", 64'(load_ready), 64'd1);
        checkFetch("restart_fetch", prog[1], 1'b0);

        // Full-depth image without load_last.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hA0000000 + 32'(i), 1'b0, 1'b0, 32'h0);
            tick();
            if (i == DEPTH - 2) begin
                checkOutput("full_pre_loaded", 64'(loaded), 64'd0);
                checkOutput("full_pre_count", 64'(load_count), 64'd255);
            end
        end
        checkOutput("full_loaded", 64'(loaded), 64'd1);
        checkOutput("full_count", 64'(load_count), 64'd256);
        checkOutput("full_load_ready", 64'(load_ready), 64'd0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        checkFetch("full_first", 32'hA0000000, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3FC);
        tick();
        checkFetch("full_last", 32'hA00000FF, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3FD);
        tick();
        checkFetch("full_misaligned", NOP, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
        tick();
        checkFetch("full_mid", 32'hA0000002, 1'b0);

        // Reset in the middle of a load.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h12340000, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h12340001, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("midload_count", 64'(load_count), 64'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("post_reset_fetch_ready", 64'(fetch_ready), 64'd0);
        checkOutput("post_reset_fetch_valid", 64'(fetch_valid), 64'd0);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("reload_loaded", 64'(loaded), 64'd1);
        checkOutput("reload_count", 64'(load_count), 64'd1);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        checkFetch("reload_word0", 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
        tick();
        checkFetch("reload_retained", 32'h12340001, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
